alu_multinibble_seq: RTL and testbench

//  Multi-cycle, parametrised successor to the 4-bit combinational ALU.

---
 rtl/alu_multinibble_seq_if.sv | 33 +++
 rtl/alu_multinibble_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_multinibble_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multinibble_seq_if.sv
// ---------------------------------------------------------------------------
// alu_multinibble_seq_if
//   Request/status bundle between the register-file side (master) and the
//   nibble-serial ALU (slave).
//   master -> slave : start, A, B, ALUop, ALUbank, Cin, enable
//   slave -> master : busy, done, flags {N,Z,V,C}
//   The tri-stated result bus is not part of this bundle. It stays a plain
//   net on the ALU so that it can share the data bus with other drivers.
// ---------------------------------------------------------------------------
interface alu_multinibble_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       ALUop;
   logic             ALUbank;
   logic             Cin;
   logic             enable;
   logic             busy;
   logic             done;
   logic [3:0]       flags;

   modport master (
      output start, A, B, ALUop, ALUbank, Cin, enable,
      input  busy, done, flags
   );

   modport slave (
      input  start, A, B, ALUop, ALUbank, Cin, enable,
      output busy, done, flags
   );
endinterface

// File: rtl/alu_multinibble_seq.sv
// ---------------------------------------------------------------------------
// alu_multinibble_seq
//   WIDTH-bit ALU that works through one 4-bit nibble per clock, LSB nibble
//   first. The carry (or the shifted-out bit for SHL) is chained from one
//   nibble to the next. Partial results build up in a shadow accumulator.
//   The visible result register and the flags are written together on the
//   done edge.
// Ports
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of alu_multinibble_seq_if (request, status, flags)
//   result  : registered result, high-Z while bus.enable == 1
// ---------------------------------------------------------------------------
module alu_multinibble_seq #(
   parameter int WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   alu_multinibble_seq_if.slave  bus,
   output wire  [WIDTH-1:0]      result
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
   logic [2:0]       op_q;
   logic             bank_q;
   logic             carry_q;   // carry, or the shifted-in bit for SHL
   logic             zero_q;    // every nibble processed so far was zero
   logic [IDXW-1:0]  idx_q;
   logic [3:0]       flags_q;
   logic             busy_q, done_q;

   // ---------------- 4-bit slice ----------------
   logic [3:0]       a_nib, b_nib, x_nib, y_nib, slice_r;
   logic [4:0]       sum5;
   logic [3:0]       lo4;
   logic             arith, slice_cout, slice_c3, slice_v, nib_zero;
   logic [WIDTH-1:0] acc_nxt;
   logic             cin0;

   assign a_nib = a_q[3:0];
   assign b_nib = b_q[3:0];

   // NOTE: every signal written in an always_comb gets a default first, so
   // no path through the case can leave one unassigned and infer a latch.
   always_comb begin
      x_nib      = a_nib;
      y_nib      = '0;
      slice_r    = '0;
      slice_cout = 1'b0;
      slice_c3   = 1'b0;
      arith      = 1'b0;
      sum5       = '0;
      lo4        = '0;
      unique case ({bank_q, op_q})
         4'b1_000: begin y_nib = b_nib;  arith = 1'b1; end  // ADD
         4'b1_001: begin y_nib = ~b_nib; arith = 1'b1; end  // SUB
         4'b1_010: slice_r = a_nib & b_nib;
         4'b1_011: slice_r = a_nib | b_nib;
         4'b1_100: slice_r = a_nib ^ b_nib;
         4'b1_101: slice_r = ~a_nib;
         4'b1_110: slice_r = a_nib;
         4'b1_111: slice_r = b_nib;
         4'b0_000: slice_r = '0;                                // ZERO
         4'b0_001: begin y_nib = 4'h0; arith = 1'b1; end        // INC
         4'b0_010: begin y_nib = 4'hF; arith = 1'b1; end        // DEC
         4'b0_011: begin x_nib = ~a_nib; arith = 1'b1; end      // NEG
         4'b0_100: begin                                        // SHL
            slice_r    = {a_nib[2:0], carry_q};
            slice_cout = a_nib[3];
         end
         4'b0_101: begin y_nib = b_nib;  arith = 1'b1; end      // ADDNC
         default:  begin y_nib = ~b_nib; arith = 1'b1; end      // SUBNC, CMP
      endcase
      if (arith) begin
         sum5       = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0, carry_q};
         lo4        = {1'b0, x_nib[2:0]} + {1'b0, y_nib[2:0]} + {3'b0, carry_q};
         slice_r    = sum5[3:0];
         slice_cout = sum5[4];
         slice_c3   = lo4[3];      // carry into bit 3 of this nibble
      end
   end

   assign slice_v  = arith & (slice_c3 ^ slice_cout);
   assign nib_zero = (slice_r == 4'h0);

   // The new nibble enters at the top, so after NIB steps nibble 0 sits at the LSB.
   always_comb begin
      acc_nxt                = acc_q >> 4;
      acc_nxt[WIDTH-1 -: 4]  = slice_r;
   end

   // Carry into nibble 0, decoded from the request being accepted.
   always_comb begin
      unique case ({bus.ALUbank, bus.ALUop})
         4'b1_000, 4'b1_001, 4'b0_100:           cin0 = bus.Cin;
         4'b0_001, 4'b0_011, 4'b0_110, 4'b0_111: cin0 = 1'b1;
         default:                                cin0 = 1'b0;
      endcase
   end

   // ---------------- control FSM and datapath registers ----------------
   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers sample the values from before the edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the operand and accumulator registers are reset along with
         // the control state, so an operation cut short by reset leaves
         // nothing behind.
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
         bank_q   <= 1'b0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         idx_q    <= '0;
         flags_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  op_q    <= bus.ALUop;
                  bank_q  <= bus.ALUbank;
                  carry_q <= cin0;
                  zero_q  <= 1'b1;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               // start is not looked at here: no queueing, no resampling.
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               acc_q   <= acc_nxt;
               carry_q <= slice_cout;
               zero_q  <= zero_q & nib_zero;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(NIB - 1)) begin
                  flags_q <= {slice_r[3], zero_q & nib_zero, slice_v, slice_cout};
                  // CMP updates the flags but leaves the visible result alone.
                  if ({bank_q, op_q} != 4'b0_111) result_q <= acc_nxt;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.flags = flags_q;
   assign result    = bus.enable ? {WIDTH{1'bz}} : result_q;

endmodule

// File: tb/tb_alu_multinibble_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_multinibble_seq
//   Directed-vector bench for alu_multinibble_seq: a WIDTH=16 instance for the
//   main scenarios and a WIDTH=4 instance for the single-nibble case.
//   Expected values are computed by hand in the vectors below.
// ---------------------------------------------------------------------------
module tb_alu_multinibble_seq;

   logic clk;
   logic reset_n;
   wire  [15:0] result16;
   wire  [3:0]  result4;

   int n_vec  = 0;
   int n_miss = 0;

   alu_multinibble_seq_if #(.WIDTH(16)) bus16 ();
   alu_multinibble_seq_if #(.WIDTH(4))  bus4 ();

   alu_multinibble_seq #(.WIDTH(16)) dut16 (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus16.slave),
      .result  (result16)
   );

   alu_multinibble_seq #(.WIDTH(4)) dut4 (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus4.slave),
      .result  (result4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a request and hold start until the accepting edge; returns #1 after it.
   task automatic issue(input logic bank, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic cin);
      @(negedge clk);
      bus16.ALUbank = bank;
      bus16.ALUop   = op;
      bus16.A       = a;
      bus16.B       = b;
      bus16.Cin     = cin;
      bus16.start   = 1'b1;
      @(posedge clk);
      #1;
      bus16.start   = 1'b0;
   endtask

   // Counts edges until done is seen (0 if it never comes), and busy samples before it.
   task automatic wait_done(output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = int'(bus16.busy);
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (bus16.done) begin
            edges = n;
            break;
         end
         busy_cnt += int'(bus16.busy);
      end
   endtask

   task automatic do_op(input string tag, input logic bank, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_res, input logic [3:0] exp_flags);
      int edges, bcnt;
      issue(bank, op, a, b, cin);
      wait_done(edges, bcnt);
      check({tag, ".lat"},   edges,            4);
      check({tag, ".res"},   {16'h0, result16}, {16'h0, exp_res});
      check({tag, ".flags"}, {28'h0, bus16.flags}, {28'h0, exp_flags});
      @(posedge clk);
      #1;
      check({tag, ".done1"}, {31'h0, bus16.done}, 0);
   endtask

   initial begin
      int edges, bcnt, dcnt;

      reset_n       = 1'b0;
      bus16.start   = 1'b0;
      bus16.A       = '0;
      bus16.B       = '0;
      bus16.ALUop   = '0;
      bus16.ALUbank = 1'b0;
      bus16.Cin     = 1'b0;
      bus16.enable  = 1'b0;
      bus4.start    = 1'b0;
      bus4.A        = '0;
      bus4.B        = '0;
      bus4.ALUop    = '0;
      bus4.ALUbank  = 1'b0;
      bus4.Cin      = 1'b0;
      bus4.enable   = 1'b0;

      // Reset state
      #12;
      check("rst.busy",   {31'h0, bus16.busy}, 0);
      check("rst.done",   {31'h0, bus16.done}, 0);
      check("rst.res",    {16'h0, result16}, 0);
      check("rst.flags",  {28'h0, bus16.flags}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // T1: ADD 0x7FFF + 0x0001 -> 0x8000, N=1 V=1, 4-edge latency, busy 4 cycles
      issue(1'b1, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
      wait_done(edges, bcnt);
      check("t1.lat",   edges, 4);
      check("t1.busy",  bcnt, 4);
      check("t1.res",   {16'h0, result16}, 32'h8000);
      check("t1.flags", {28'h0, bus16.flags}, 32'hA);
      @(posedge clk);
      #1;
      check("t1.done1", {31'h0, bus16.done}, 0);

      // T2: SUB equal operands, then CMP leaves result untouched
      do_op("t2.sub", 1'b1, 3'd1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b0101);
      do_op("t2.add", 1'b1, 3'd0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 4'b0000);
      do_op("t2.cmp", 1'b0, 3'd7, 16'h0001, 16'h0002, 1'b0, 16'h3333, 4'b1000);

      // T3: start during RUN is ignored; start in the done cycle is accepted
      issue(1'b1, 3'd0, 16'h0100, 16'h0011, 1'b0);
      @(posedge clk);
      #1;
      bus16.A     = 16'hF000;
      bus16.ALUop = 3'd4;
      bus16.start = 1'b1;
      @(posedge clk);
      #1;
      bus16.start = 1'b0;
      wait_done(edges, bcnt);
      check("t3.lat",   edges, 2);
      check("t3.res",   {16'h0, result16}, 32'h0111);
      check("t3.flags", {28'h0, bus16.flags}, 32'h0);
      bus16.ALUbank = 1'b1;
      bus16.ALUop   = 3'd0;
      bus16.A       = 16'h8FFF;
      bus16.B       = 16'h8001;
      bus16.Cin     = 1'b0;
      bus16.start   = 1'b1;
      @(posedge clk);
      #1;
      bus16.start   = 1'b0;
      check("t3.b2b_busy", {31'h0, bus16.busy}, 1);
      wait_done(edges, bcnt);
      check("t3.b2b_lat",   edges, 4);
      check("t3.b2b_res",   {16'h0, result16}, 32'h1000);
      check("t3.b2b_flags", {28'h0, bus16.flags}, 32'h3);
      @(posedge clk);

      // T4: reset in the middle of RUN discards the operation
      issue(1'b1, 3'd0, 16'h0001, 16'h0001, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t4.busy",  {31'h0, bus16.busy}, 0);
      check("t4.done",  {31'h0, bus16.done}, 0);
      check("t4.res",   {16'h0, result16}, 0);
      check("t4.flags", {28'h0, bus16.flags}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      dcnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         dcnt += int'(bus16.done);
      end
      check("t4.nodone", dcnt, 0);
      check("t4.idle",   {31'h0, bus16.busy}, 0);

      // T5: SHL, NEG of zero, plus a few more ops
      do_op("t5.shl",  1'b0, 3'd4, 16'h8421, 16'h0000, 1'b1, 16'h0843, 4'b0001);
      do_op("t5.neg",  1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0101);
      do_op("t5.and",  1'b1, 3'd2, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 4'b1000);
      do_op("t5.dec",  1'b0, 3'd2, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b1000);
      do_op("t5.inc",  1'b0, 3'd1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b0101);
      do_op("t5.pasb", 1'b1, 3'd7, 16'h1234, 16'h5A5A, 1'b1, 16'h5A5A, 4'b0000);

      // T6: output disabled while the op still completes; then re-enabled
      bus16.enable = 1'b1;
      issue(1'b1, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
      wait_done(edges, bcnt);
      check("t6.lat",   edges, 4);
      check("t6.flags", {28'h0, bus16.flags}, 32'hA);
      check("t6.float", {31'h0, (result16 !== 16'h8000)}, 1);
      bus16.enable = 1'b0;
      #1;
      check("t6.res",   {16'h0, result16}, 32'h8000);

      // T6: WIDTH=4 instance, ADD 0x7 + 0x1 -> 0x8 one edge after start
      @(negedge clk);
      bus4.ALUbank = 1'b1;
      bus4.ALUop   = 3'd0;
      bus4.A       = 4'h7;
      bus4.B       = 4'h1;
      bus4.Cin     = 1'b0;
      bus4.start   = 1'b1;
      @(posedge clk);
      #1;
      bus4.start   = 1'b0;
      check("w4.busy", {31'h0, bus4.busy}, 1);
      @(posedge clk);
      #1;
      check("w4.done",  {31'h0, bus4.done}, 1);
      check("w4.res",   {28'h0, result4}, 32'h8);
      check("w4.flags", {28'h0, bus4.flags}, 32'hA);
      @(posedge clk);
      #1;
      check("w4.done1", {31'h0, bus4.done}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
